sn74169_ctrl: RTL and testbench
===============================

Name: sn74169_ctrl

Overview:
- Controller that drives the control side of an SN74169-compatible synchronous up/down counter and watches its Q and RCOB returns.
- Loads a preset, runs the counter up or down to terminal count, and either stops (one-shot) or reloads (auto-reload, programmable divider).
- Tracks an expected count and flags any disagreement with the counter's Q or RCOB; used as the bench-facing/host-facing master for counter tiles.

Parameters:
- WIDTH, 4, counter width in bits (multiple of 4, one SN74169 per nibble in a cascade).
- CNT_W, 8, width of the terminal-count event counter tc_cnt (saturating).

Ports:
- clk  in  1  clock; counter and controller share this edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- abort  in  1  return to IDLE from any state (except during rst).
- dir  in  1  1=count up, 0=count down; captured on accepted start.
- reload  in  1  1=auto-reload, 0=one-shot; captured on accepted start.
- preset  in  WIDTH  load value; captured on accepted start.
- A  out  WIDTH  parallel-load data to counter.
- LOADB  out  1  active-low load.
- ENPB  out  1  active-low count enable P.
- ENTB  out  1  active-low count enable T.
- U_DB  out  1  1=up, 0=down.
- Q  in  WIDTH  counter output.
- RCOB  in  1  counter active-low ripple carry.
- busy  out  1  high in LOAD/RUN.
- done  out  1  one-cycle pulse per terminal count reached.
- err  out  1  sticky mismatch flag.
- tc_cnt  out  CNT_W  terminal counts since last accepted start, saturates at all-ones.

Behaviour:
- All outputs registered (Moore). Reset / IDLE / ERR drive: LOADB=1, ENPB=1, ENTB=1, U_DB=1, A=0, busy=0, done=0. Reset also clears err, tc_cnt, exp, and all captured values, and enters IDLE.
- States: IDLE, LOAD, RUN, ERR.
- IDLE: on start=1, capture preset, dir and reload; clear tc_cnt; go to LOAD.
- LOAD (one cycle):
  - Drive LOADB=0, A=preset, ENPB=ENTB=1, U_DB=dir, busy=1.
  - Set exp=preset; go to RUN.
- RUN:
  - Drive LOADB=1, ENPB=ENTB=0, U_DB=dir, busy=1.
  - Each cycle check Q==exp and (RCOB==0) == (exp==term). term is all-ones if dir=1, else 0. Any miss: set err, go to ERR.
  - Otherwise exp <= exp±1 modulo 2^WIDTH.
  - When exp==term (RCOB low), the counter wraps on this edge. Pulse done next cycle, increment tc_cnt, then:
    - reload=1: go to LOAD.
    - reload=0: go to IDLE.
- Period, auto-reload, up: (2^WIDTH − preset) RUN cycles + 1 LOAD cycle. Down: (preset+1) RUN cycles + 1 LOAD cycle.
- preset==term: first RUN cycle is terminal, giving a 2-cycle period.
- ERR: err held; controls inactive. Exit only via rst, or via abort, which goes to IDLE with err still set until the next accepted start clears it.
- abort has priority over every other transition. It goes to IDLE on that edge; a done pending on that edge is suppressed and tc_cnt is not incremented.
- start while busy is ignored. start and abort together in IDLE: abort wins, stay IDLE.
- Q and RCOB are not checked outside RUN.

Test Plan:
- Reset: rst=1 for 2 cycles -> LOADB=ENPB=ENTB=U_DB=1, busy=0, err=0, tc_cnt=0.
- One-shot up, preset=4'hC, with a reference counter model attached:
  - LOADB low 1 cycle, then 4 RUN cycles with Q=C,D,E,F.
  - done pulses once; tc_cnt=1; back to IDLE; counter holds 0.
- Auto-reload down, preset=4'h2: done every 4 cycles (LOAD + Q=2,1,0), tc_cnt=5 after 20 cycles of RUN/LOAD; no err.
- preset=4'hF up with reload: 2-cycle period; done every other cycle.
- Fault injection, model Q stuck at 4'h5 with preset=3 up: err=1 at the second RUN cycle; controls inactive; err stays set until the next accepted start.
- Mid-run events:
  - abort in RUN at Q=7: next cycle ENPB=ENTB=1, busy=0, no done.
  - start asserted while busy: no effect on sequence or captured preset.

Source files
------------

// File: rtl/sn74169_ctrl.sv
// Control-side master for an SN74169-compatible synchronous up/down counter
// (one device per nibble when cascaded). Loads a preset, runs the counter to
// terminal count, then either stops (one-shot) or reloads (programmable
// divider). An expected count is tracked alongside the counter, and any
// disagreement with Q or RCOB latches a sticky error.
module sn74169_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic             reload,
    input  logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] A,
    output logic             LOADB,
    output logic             ENPB,
    output logic             ENTB,
    output logic             U_DB,
    input  logic [WIDTH-1:0] Q,
    input  logic             RCOB,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] tc_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] EXP_ONE = WIDTH'(1);
    localparam logic [CNT_W-1:0] TC_ONE  = CNT_W'(1);

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   preset_q, preset_d;
    logic               dir_q,    dir_d;
    logic               reload_q, reload_d;
    logic [WIDTH-1:0]   exp_q,    exp_d;
    logic               err_q,    err_d;
    logic [CNT_W-1:0]   tc_cnt_q, tc_cnt_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic               loadb_q,  loadb_d;
    logic               enpb_q,   enpb_d;
    logic               entb_q,   entb_d;
    logic               u_db_q,   u_db_d;
    logic               busy_q,   busy_d;

    logic [WIDTH-1:0]   term;
    logic               at_term;
    logic               chk_ok;

    // Terminal value follows the captured direction; the counter's RCOB must
    // be low exactly when the expected count sits on it.
    always_comb begin
        term    = {WIDTH{dir_q}};
        at_term = (exp_q == term);
        chk_ok  = (Q == exp_q) && ((!RCOB) == at_term);
    end

    // Next-state, captured values, and Moore outputs decoded from the next state.
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        dir_d    = dir_q;
        reload_d = reload_q;
        exp_d    = exp_q;
        err_d    = err_q;
        tc_cnt_d = tc_cnt_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    preset_d = preset;
                    dir_d    = dir;
                    reload_d = reload;
                    tc_cnt_d = '0;
                    err_d    = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                exp_d   = preset_q;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!chk_ok) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    exp_d = dir_q ? (exp_q + EXP_ONE) : (exp_q - EXP_ONE);
                    if (at_term) begin
                        // Counter wraps on this edge; report it in the next cycle.
                        done_d = 1'b1;
                        if (tc_cnt_q != {CNT_W{1'b1}}) begin
                            tc_cnt_d = tc_cnt_q + TC_ONE;
                        end
                        state_d = reload_q ? S_LOAD : S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        // Abort overrides everything: no capture, no done, no count, err untouched.
        if (abort) begin
            state_d  = S_IDLE;
            preset_d = preset_q;
            dir_d    = dir_q;
            reload_d = reload_q;
            exp_d    = exp_q;
            err_d    = err_q;
            tc_cnt_d = tc_cnt_q;
            done_d   = 1'b0;
        end

        loadb_d = 1'b1;
        enpb_d  = 1'b1;
        entb_d  = 1'b1;
        u_db_d  = 1'b1;
        a_d     = '0;
        busy_d  = 1'b0;
        case (state_d)
            S_LOAD: begin
                loadb_d = 1'b0;
                a_d     = preset_d;
                u_db_d  = dir_d;
                busy_d  = 1'b1;
            end
            S_RUN: begin
                enpb_d  = 1'b0;
                entb_d  = 1'b0;
                u_db_d  = dir_d;
                busy_d  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            preset_q <= '0;
            dir_q    <= 1'b0;
            reload_q <= 1'b0;
            exp_q    <= '0;
            err_q    <= 1'b0;
            tc_cnt_q <= '0;
            done_q   <= 1'b0;
            a_q      <= '0;
            loadb_q  <= 1'b1;
            enpb_q   <= 1'b1;
            entb_q   <= 1'b1;
            u_db_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            dir_q    <= dir_d;
            reload_q <= reload_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            tc_cnt_q <= tc_cnt_d;
            done_q   <= done_d;
            a_q      <= a_d;
            loadb_q  <= loadb_d;
            enpb_q   <= enpb_d;
            entb_q   <= entb_d;
            u_db_q   <= u_db_d;
            busy_q   <= busy_d;
        end
    end

    assign A      = a_q;
    assign LOADB  = loadb_q;
    assign ENPB   = enpb_q;
    assign ENTB   = entb_q;
    assign U_DB   = u_db_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign tc_cnt = tc_cnt_q;

endmodule

// File: tb/tb_sn74169_ctrl.sv
// Bench for sn74169_ctrl: an SN74169 behavioural counter closes the loop, and
// expected controller outputs come from the period arithmetic of each sequence.
module tb_sn74169_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int MODN  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst, start, abort, dir, reload;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] A;
    logic             LOADB, ENPB, ENTB, U_DB;
    logic [WIDTH-1:0] Q;
    logic             RCOB;
    logic             busy, done, err;
    logic [CNT_W-1:0] tc_cnt;

    logic [WIDTH-1:0] cnt = '0;
    bit               stuck = 1'b0;

    int total = 0;
    int bad   = 0;

    sn74169_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dir(dir),
        .reload(reload), .preset(preset), .A(A), .LOADB(LOADB), .ENPB(ENPB),
        .ENTB(ENTB), .U_DB(U_DB), .Q(Q), .RCOB(RCOB), .busy(busy),
        .done(done), .err(err), .tc_cnt(tc_cnt)
    );

    always #5 clk = ~clk;

    // SN74169 behaviour: load has priority, counts only with both enables low.
    always @(posedge clk) begin
        if (!LOADB)
            cnt <= A;
        else if (!ENPB && !ENTB)
            cnt <= U_DB ? cnt + 4'd1 : cnt - 4'd1;
    end
    assign Q    = stuck ? 4'h5 : cnt;
    assign RCOB = !(!ENTB && (Q == (U_DB ? 4'hF : 4'h0)));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag, input int exp_tc, input bit exp_err);
        chk({tag, ".loadb"}, LOADB, 1);
        chk({tag, ".enpb"},  ENPB, 1);
        chk({tag, ".entb"},  ENTB, 1);
        chk({tag, ".busy"},  busy, 0);
        chk({tag, ".done"},  done, 0);
        chk({tag, ".tc"},    tc_cnt, exp_tc);
        chk({tag, ".err"},   err, exp_err);
    endtask

    // Starts a sequence at a negedge and checks ncyc cycles from the LOAD cycle on.
    // With noise, start/preset/dir/reload are scrambled while the DUT is busy.
    task automatic run_seq(input logic [WIDTH-1:0] p, input bit d, input bit r,
                           input int ncyc, input bit noise, output int tc_last);
        int per, phase, c, qexp;
        per = d ? (MODN - int'(p)) : (int'(p) + 1);
        preset = p; dir = d; reload = r; start = 1'b1;
        tc_last = 0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            if (noise && (r || t < per + 1)) begin
                start  = 1'($urandom);
                preset = 4'($urandom);
                dir    = 1'($urandom);
                reload = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            chk($sformatf("p%0h d%0d r%0d t%0d err", p, d, r, t), err, 0);
            if (!r && t >= per + 1) begin
                chk($sformatf("p%0h t%0d idle_busy", p, t), busy, 0);
                chk($sformatf("p%0h t%0d idle_enpb", p, t), ENPB, 1);
                chk($sformatf("p%0h t%0d idle_done", p, t), done, (t == per + 1));
                chk($sformatf("p%0h t%0d idle_tc", p, t), tc_cnt, 1);
                qexp = d ? 0 : MODN - 1;
                chk($sformatf("p%0h t%0d hold_q", p, t), Q, qexp);
                tc_last = 1;
            end else begin
                phase = t % (per + 1);
                c     = t / (per + 1);
                if (c > 255) c = 255;
                tc_last = c;
                chk($sformatf("p%0h t%0d busy", p, t), busy, 1);
                chk($sformatf("p%0h t%0d u_db", p, t), U_DB, d);
                chk($sformatf("p%0h t%0d tc", p, t), tc_cnt, c);
                if (phase == 0) begin
                    chk($sformatf("p%0h t%0d loadb", p, t), LOADB, 0);
                    chk($sformatf("p%0h t%0d a", p, t), A, p);
                    chk($sformatf("p%0h t%0d enpb_ld", p, t), ENPB, 1);
                    chk($sformatf("p%0h t%0d done_ld", p, t), done, (t > 0));
                end else begin
                    qexp = d ? (int'(p) + phase - 1) % MODN
                             : (int'(p) - (phase - 1) + MODN) % MODN;
                    chk($sformatf("p%0h t%0d loadb_run", p, t), LOADB, 1);
                    chk($sformatf("p%0h t%0d en_run", p, t), {ENPB, ENTB}, 0);
                    chk($sformatf("p%0h t%0d done_run", p, t), done, 0);
                    chk($sformatf("p%0h t%0d q", p, t), Q, qexp);
                end
            end
        end
        start = 1'b0;
    endtask

    // Abort (with a random start alongside) and confirm the return to IDLE.
    task automatic do_abort(input string tag, input int exp_tc, input bit exp_err);
        abort = 1'b1;
        start = 1'($urandom);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk_idle(tag, exp_tc, exp_err);
        $display("abort %s tc=%0d err=%0d", tag, tc_cnt, err);
    endtask

    initial begin
        int tcl;
        logic [WIDTH-1:0] rp;
        bit rd, rr;
        int per, n;

        rst = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0; reload = 1'b0; preset = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset", 0, 0);
        chk("reset.u_db", U_DB, 1);
        chk("reset.a", A, 0);
        $display("reset loadb=%0b enpb=%0b entb=%0b u_db=%0b", LOADB, ENPB, ENTB, U_DB);
        rst = 1'b0;
        @(negedge clk);

        // One-shot up from C: LOAD, Q=C..F, done, idle with counter at 0.
        run_seq(4'hC, 1'b1, 1'b0, 7, 1'b0, tcl);
        $display("oneshot_up p=C tc=%0d q=%0h", tc_cnt, Q);

        // Auto-reload down from 2: period 4, five terminal counts in 20 cycles.
        run_seq(4'h2, 1'b0, 1'b1, 21, 1'b0, tcl);
        $display("reload_down p=2 tc=%0d", tc_cnt);
        do_abort("reload_down", tcl, 0);

        // Preset at terminal with reload: 2-cycle period.
        run_seq(4'hF, 1'b1, 1'b1, 12, 1'b0, tcl);
        $display("reload_up p=F tc=%0d", tc_cnt);
        do_abort("reload_upF", tcl, 0);

        // Fault: Q stuck at 5 while preset=3 up.
        stuck = 1'b1;
        preset = 4'h3; dir = 1'b1; reload = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("fault.load", LOADB, 0);
        @(negedge clk);
        chk("fault.run1_err", err, 0);
        chk("fault.run1_busy", busy, 1);
        @(negedge clk);
        chk_idle("fault.err", 0, 1);
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle("fault.start_in_err", 0, 1);
        end
        start = 1'b0;
        do_abort("fault", 0, 1);
        @(negedge clk);
        chk("fault.idle_err_held", err, 1);
        $display("fault err=%0b busy=%0b", err, busy);
        stuck = 1'b0;
        run_seq(4'h3, 1'b1, 1'b0, 15, 1'b0, tcl);
        $display("fault_recover tc=%0d err=%0b", tc_cnt, err);

        // Abort at Q=7 (preset 4 up), with start noise while busy.
        run_seq(4'h4, 1'b1, 1'b0, 5, 1'b1, tcl);
        chk("abort.q7", Q, 7);
        do_abort("abort_q7", 0, 0);

        // Random sequences, each ended by an abort.
        for (int k = 0; k < 8; k++) begin
            rp = 4'($urandom);
            rd = 1'($urandom);
            rr = 1'($urandom);
            per = rd ? (MODN - int'(rp)) : (int'(rp) + 1);
            n = rr ? int'($urandom_range(1, 40)) : int'($urandom_range(1, per + 2));
            run_seq(rp, rd, rr, n, 1'b1, tcl);
            $display("random k=%0d p=%0h d=%0d r=%0d n=%0d tc=%0d", k, rp, rd, rr, n, tc_cnt);
            do_abort($sformatf("random%0d", k), tcl, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
